matrix_alu_ahb: RTL and testbench
=================================

// Module: matrix_alu_ahb
// PURPOSE
//  AHB-Lite slave holding two DEPTH-element operand vectors A and B and a result vector R.
//  A CTRL write starts an element-wise operation: add, sub, mul (low DATA_W bits) or unsigned max.
//  Processes LANES elements/cycle; STATUS and a level IRQ report completion.
//  Sits on the AHB-Lite peripheral bus beside the other accelerators.
// PARAMETERS
//  DATA_W  32  element width in bits; bus words are 32b, DATA_W<=32, zero-extended on read
//  DEPTH   64  elements per vector; power of 2, 4..256
//  LANES    4  elements computed per CALC cycle; power of 2, divides DEPTH
// PORTS
//  HCLK       in   1       bus clock; all logic on rising edge
//  HRESET     in   1       synchronous, active-high reset
//  HSEL       in   1       slave select
//  HREADY     in   1       bus ready; address phase accepted only when 1
//  HADDR      in   32      byte address
//  HTRANS     in   2       transfer type; HTRANS[1]=1 means valid (NONSEQ/SEQ)
//  HWRITE     in   1       1=write
//  HSIZE      in   3       ignored; all accesses treated as 32b words
//  HWDATA     in   32      write data (data phase)
//  HREADYOUT  out  1       0 = wait state
//  HRDATA     out  32      read data
//  HRESP      out  1       constant 0 (OKAY)
//  IRQ        out  1       equals STATUS.DONE
// BEHAVIOUR
//  Address decode (AW=log2 DEPTH)
//   - Region = HADDR[AW+3:AW+2]; index = HADDR[AW+1:2].
//   - Region 0 = A (RW), region 1 = B (RW), region 2 = R (RO), region 3 = regs.
//   - Reg idx0 CTRL: wr bit0=START, bits2:1=MODE (00 add, 01 sub, 10 mul, 11 max). Rd: {29'b0, MODE, 1'b0}.
//   - Reg idx1 STATUS: bit0 BUSY, bit1 DONE, bit2 WERR. Write 1 to bit1/bit2 clears it. Other reg idx read 0.
//  Bus phases
//   - Address phase is registered when HSEL & HREADY & HTRANS[1].
//   - Write takes effect at end of data phase, using HWDATA[DATA_W-1:0].
//   - Read data is valid in the data phase (HRDATA registered at address phase).
//   - Writes to region 2 are ignored.
//  Reset values
//   - HREADYOUT=1, HRDATA=0, HRESP=0, IRQ=0.
//   - MODE=00, BUSY=DONE=WERR=0, FSM=IDLE.
//   - A/B/R contents are not reset.
//  FSM: IDLE -> CALC -> DONE -> IDLE
//   - IDLE: a CTRL write with START=1 latches MODE, clears ptr, sets BUSY, enters CALC on the next cycle.
//   - CALC: per cycle, R[ptr+k] = op(A[ptr+k], B[ptr+k]) for k=0..LANES-1; ptr += LANES.
//   - CALC lasts exactly DEPTH/LANES cycles (16 by default).
//   - DONE (1 cycle): BUSY=0, DONE=1, return to IDLE.
//  Arithmetic
//   - add/sub wrap modulo 2^DATA_W; mul keeps the low DATA_W bits; max is unsigned.
//  Busy rules
//   - A/B write while BUSY: dropped, WERR set. START while BUSY: ignored, WERR set.
//   - R read while BUSY: HREADYOUT=0 in the data phase until the FSM reaches DONE.
//     Correct R data returns with HREADYOUT=1 the cycle after DONE.
//   - A/B/reg reads never stall.
//  Simultaneous events
//   - DONE set (FSM) and a W1C clear in the same cycle: set wins.
//   - START write and DONE clear in the same word both apply; DONE clears, then a new run begins.
//  Reset mid-CALC
//   - Aborts: FSM=IDLE, BUSY=0, HREADYOUT=1. R is partially updated and undefined.
// TESTING
//  - Wr A[i]=i, B[i]=2i for all i; CTRL=0x1 -> BUSY for 16 CALC cycles, then R[i]=3i, DONE=1, IRQ=1.
//  - MODE sub, A[0]=0, B[0]=1 -> R[0]=0xFFFFFFFF; MODE mul 0x10000*0x10000 -> 0; max(5,9) -> 9.
//  - Read R[63] one cycle after START -> HREADYOUT low until DONE, then data=A[63] op B[63].
//  - Write A[3] while BUSY -> A[3] unchanged, WERR=1; write 0x4 to STATUS -> WERR=0.
//  - Write 0x2 to STATUS -> DONE=0, IRQ=0. Same cycle as DONE set -> DONE stays 1.
//  - Assert HRESET at CALC cycle 5 -> next cycle BUSY=0, HREADYOUT=1, new START completes normally.

Source files
------------

// File: rtl/matrix_alu_ahb.sv
// AHB-Lite slave holding operand vectors A and B and result vector R.
// A CTRL write with START runs an element-wise add/sub/mul/max over all
// DEPTH elements, LANES elements per cycle, then flags DONE (mirrored on IRQ).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for START; bus has full access to A/B/R
//   S_CALC | computing LANES results per cycle; BUSY=1, A/B writes dropped
//   S_DONE | one cycle after the last CALC; stalled R reads are served here
module matrix_alu_ahb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int LANES  = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        IRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - LANES);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [AW-1:0] ptr;
  logic [1:0]    mode;
  logic          done, werr, busy;

  logic          dp_valid, dp_write, r_pend;
  logic [1:0]    dp_region;
  logic [AW-1:0] dp_idx;

  logic          addr_ok;
  logic [1:0]    a_region;
  logic [AW-1:0] a_idx;
  logic          wr, wr_ab, wr_ctrl, wr_stat, start_req, start_ok, err_set, calc_last;
  logic [31:0]   rd_word, r_pend_word;
  logic          unused;

  function automatic logic [DATA_W-1:0] alu_op(input logic [1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      2'b00:   alu_op = a + b;
      2'b01:   alu_op = a - b;
      2'b10:   alu_op = a * b;
      default: alu_op = (a > b) ? a : b;
    endcase
  endfunction

  assign addr_ok   = HSEL & HREADY & HTRANS[1];
  assign a_region  = HADDR[AW+3:AW+2];
  assign a_idx     = HADDR[AW+1:2];

  assign busy      = (state == S_CALC);
  assign calc_last = busy && (ptr == LAST_PTR);

  assign wr        = dp_valid & dp_write;
  assign wr_ab     = wr & ~dp_region[1];
  assign wr_ctrl   = wr & (dp_region == 2'd3) & (dp_idx == '0);
  assign wr_stat   = wr & (dp_region == 2'd3) & (dp_idx == AW'(1));
  assign start_req = wr_ctrl & HWDATA[0];
  assign start_ok  = start_req & ~busy;
  assign err_set   = (wr_ab | start_req) & busy;

  assign HRESP  = 1'b0;
  assign IRQ    = done;
  assign unused = ^{HSIZE, HADDR[31:AW+4], HADDR[1:0], HTRANS[0], HWDATA};

  // FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state; a START arriving in S_DONE chains straight into a new run
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nxt = S_CALC;
      S_CALC:  if (calc_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start_ok ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run control and status; FSM setting DONE/WERR beats a same-cycle W1C
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ptr  <= '0;
      mode <= 2'b00;
      done <= 1'b0;
      werr <= 1'b0;
    end else begin
      if (start_ok)  ptr <= '0;
      else if (busy) ptr <= ptr + AW'(LANES);
      if (start_ok) mode <= HWDATA[2:1];
      if (calc_last)                                done <= 1'b1;
      else if ((wr_stat && HWDATA[1]) || start_ok)  done <= 1'b0;
      if (err_set)                   werr <= 1'b1;
      else if (wr_stat && HWDATA[2]) werr <= 1'b0;
    end
  end

  // Operand writes from the bus, dropped while a run is in progress
  always_ff @(posedge HCLK) begin
    if (wr_ab && !busy) begin
      if (dp_region[0]) mem_b[dp_idx] <= HWDATA[DATA_W-1:0];
      else              mem_a[dp_idx] <= HWDATA[DATA_W-1:0];
    end
  end

  // LANES-wide result datapath
  always_ff @(posedge HCLK) begin
    if (busy) begin
      for (int k = 0; k < LANES; k++)
        mem_r[ptr + AW'(k)] <= alu_op(mode, mem_a[ptr + AW'(k)], mem_b[ptr + AW'(k)]);
    end
  end

  // Read mux at address phase, forwarding an A/B write in its data phase
  always_comb begin
    rd_word = '0;
    case (a_region)
      2'd0: rd_word[DATA_W-1:0] = mem_a[a_idx];
      2'd1: rd_word[DATA_W-1:0] = mem_b[a_idx];
      2'd2: rd_word[DATA_W-1:0] = mem_r[a_idx];
      default: begin
        if (a_idx == '0)          rd_word = {29'b0, mode, 1'b0};
        else if (a_idx == AW'(1)) rd_word = {29'b0, werr, done, busy};
      end
    endcase
    if (wr_ab && !busy && (dp_region == a_region) && (dp_idx == a_idx))
      rd_word[DATA_W-1:0] = HWDATA[DATA_W-1:0];
    r_pend_word = '0;
    r_pend_word[DATA_W-1:0] = mem_r[dp_idx];
  end

  // Bus pipeline; R reads issued during (or at the start of) a run wait for S_DONE
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_region <= 2'd0;
      dp_idx    <= '0;
      r_pend    <= 1'b0;
      HREADYOUT <= 1'b1;
      HRDATA    <= '0;
    end else begin
      dp_valid <= addr_ok;
      if (addr_ok) begin
        dp_write  <= HWRITE;
        dp_region <= a_region;
        dp_idx    <= a_idx;
      end
      if (r_pend) begin
        if (state == S_DONE) begin
          HRDATA    <= r_pend_word;
          HREADYOUT <= 1'b1;
          r_pend    <= 1'b0;
        end
      end else if (addr_ok && !HWRITE) begin
        if ((a_region == 2'd2) && (busy || start_ok)) begin
          HREADYOUT <= 1'b0;
          r_pend    <= 1'b1;
        end else begin
          HRDATA <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_alu_ahb.sv
// Directed bench for matrix_alu_ahb: operand load, all four modes, R-read
// stall, busy-write errors, W1C versus DONE-set collision and mid-run reset.
module tb_matrix_alu_ahb;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, HRESP, IRQ;
  logic [31:0] HRDATA;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] A_BASE = 32'h000;
  localparam logic [31:0] B_BASE = 32'h100;
  localparam logic [31:0] R_BASE = 32'h200;
  localparam logic [31:0] CTRL   = 32'h300;
  localparam logic [31:0] STAT   = 32'h304;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  matrix_alu_ahb dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .HRESP(HRESP), .IRQ(IRQ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Tasks start and end #1 after a rising edge.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 200) begin
      @(posedge HCLK); #1;
      waits++;
    end
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    ahb_read(addr, d, w);
    check(tag, d, exp);
  endtask

  task automatic wait_irq(output int cyc);
    cyc = 0;
    while (IRQ !== 1'b1 && cyc < 200) begin
      @(posedge HCLK); #1;
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w, cyc;

    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HADDR = '0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hresp", {31'b0, HRESP}, 32'd0);
    check("rst_irq", {31'b0, IRQ}, 32'd0);
    read_chk("rst_status", STAT, 32'd0);
    read_chk("rst_ctrl", CTRL, 32'd0);

    for (int i = 0; i < 64; i++) begin
      ahb_write(A_BASE + 32'(i * 4), 32'(i));
      ahb_write(B_BASE + 32'(i * 4), 32'(2 * i));
    end
    read_chk("rd_a7", A_BASE + 32'd28, 32'd7);
    read_chk("rd_b7", B_BASE + 32'd28, 32'd14);

    // add run
    ahb_write(CTRL, 32'h1);
    check("irq_low_at_start", {31'b0, IRQ}, 32'd0);
    wait_irq(cyc);
    check("add_latency", 32'(cyc), 32'd16);
    read_chk("add_status", STAT, 32'h2);
    read_chk("add_r0", R_BASE + 32'd0, 32'd0);
    read_chk("add_r1", R_BASE + 32'd4, 32'd3);
    read_chk("add_r33", R_BASE + 32'd132, 32'd99);
    read_chk("add_r63", R_BASE + 32'd252, 32'd189);
    ahb_write(R_BASE + 32'd4, 32'h1234);
    read_chk("r_write_ignored", R_BASE + 32'd4, 32'd3);

    ahb_write(STAT, 32'h2);
    check("done_w1c_irq", {31'b0, IRQ}, 32'd0);
    read_chk("done_w1c_status", STAT, 32'd0);

    // sub
    ahb_write(A_BASE, 32'd0);
    ahb_write(B_BASE, 32'd1);
    ahb_write(CTRL, 32'h3);
    wait_irq(cyc);
    check("sub_latency", 32'(cyc), 32'd16);
    read_chk("sub_r0", R_BASE, 32'hFFFF_FFFF);
    read_chk("sub_ctrl_mode", CTRL, 32'h2);
    ahb_write(STAT, 32'h2);

    // mul
    ahb_write(A_BASE + 32'd4, 32'h0001_0000);
    ahb_write(B_BASE + 32'd4, 32'h0001_0000);
    ahb_write(A_BASE + 32'd8, 32'd3);
    ahb_write(B_BASE + 32'd8, 32'd5);
    ahb_write(CTRL, 32'h5);
    wait_irq(cyc);
    read_chk("mul_r1_wrap", R_BASE + 32'd4, 32'd0);
    read_chk("mul_r2", R_BASE + 32'd8, 32'd15);
    read_chk("mul_ctrl_mode", CTRL, 32'h4);
    ahb_write(STAT, 32'h2);

    // max (unsigned)
    ahb_write(A_BASE + 32'd16, 32'd5);
    ahb_write(B_BASE + 32'd16, 32'd9);
    ahb_write(A_BASE + 32'd20, 32'hFFFF_FFFF);
    ahb_write(B_BASE + 32'd20, 32'd1);
    ahb_write(CTRL, 32'h7);
    wait_irq(cyc);
    read_chk("max_r4", R_BASE + 32'd16, 32'd9);
    read_chk("max_r5_unsigned", R_BASE + 32'd20, 32'hFFFF_FFFF);
    ahb_write(STAT, 32'h2);

    // R read one cycle after START stalls until DONE
    ahb_write(CTRL, 32'h1);
    ahb_read(R_BASE + 32'd252, d, w);
    check("stall_waits", 32'(w), 32'd16);
    check("stall_data", d, 32'd189);
    ahb_write(STAT, 32'h2);

    // writes while busy
    ahb_write(CTRL, 32'h1);
    ahb_write(A_BASE + 32'd12, 32'hDEAD);
    read_chk("werr_busy_status", STAT, 32'h5);
    ahb_write(CTRL, 32'h1);
    wait_irq(cyc);
    check("start_busy_ignored", 32'(cyc), 32'd10);
    read_chk("a3_unchanged", A_BASE + 32'd12, 32'd3);
    read_chk("werr_done_status", STAT, 32'h6);
    ahb_write(STAT, 32'h4);
    read_chk("werr_w1c", STAT, 32'h2);
    ahb_write(STAT, 32'h2);
    read_chk("all_clear", STAT, 32'd0);

    // W1C of DONE lands on the same edge DONE is set
    ahb_write(CTRL, 32'h1);
    repeat (14) @(posedge HCLK);
    #1;
    ahb_write(STAT, 32'h2);
    check("done_set_wins_irq", {31'b0, IRQ}, 32'd1);
    read_chk("done_set_wins_status", STAT, 32'h2);
    ahb_write(STAT, 32'h2);

    // reset during CALC with an R read stalled
    ahb_write(CTRL, 32'h1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = R_BASE + 32'd252;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    check("midrun_stalled", {31'b0, HREADYOUT}, 32'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    check("midrun_rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("midrun_rst_irq", {31'b0, IRQ}, 32'd0);
    check("midrun_rst_hrdata", HRDATA, 32'd0);
    read_chk("midrun_rst_status", STAT, 32'd0);
    ahb_write(CTRL, 32'h1);
    wait_irq(cyc);
    check("post_rst_latency", 32'(cyc), 32'd16);
    read_chk("post_rst_r10", R_BASE + 32'd40, 32'd30);
    read_chk("post_rst_status", STAT, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
